mux_n_pipe: RTL and testbench
=============================

# mux_n_pipe

Parametrised N-input, WIDTH-bit selector with a registered, valid/ready-handshaked output stage. Generalised successor of the processor's fixed 5-bit 2:1 selector, for register-address, ALU-operand and write-back selection once the datapath is pipelined. It forwards the channel chosen by `sel` to a one-cycle output register, tags the result with its source channel and applies backpressure to the selected input only.

## Interface
- `WIDTH`, 5, data bits per channel
- `N`, 2, number of input channels (N ≥ 2, need not be a power of two)
- `SEL_W`, `$clog2(N)`, select width (derived; do not override)
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_data`  in  N*WIDTH  packed channels; channel i at bits [i*WIDTH +: WIDTH]
- `in_valid`  in  N  per-channel valid
- `in_ready`  out  N  per-channel ready; at most one bit high
- `sel`  in  SEL_W  channel select, sampled only on an accepting cycle
- `out_data`  out  WIDTH  registered selected data
- `out_src`  out  SEL_W  channel index that produced `out_data`
- `out_valid`  out  1  output holds a word
- `out_ready`  in  1  downstream accepts

## Operation
- `in_ready[i]` = (i == sel) && (sel < N) && `can_accept`; all other bits 0.
- Accept on channel sel when `in_valid[sel] && in_ready[sel]`: capture `in_data[sel]` and `sel` into the output stage.
- Output transfer when `out_valid && out_ready`.
- `sel` ≥ N (non-power-of-two N): no ready asserted, nothing accepted, no error flagged.
- Unselected channels are never consumed regardless of `in_valid`.
- Held output is independent of later `sel`/`in_data` changes.
- Base mode (no skid): single register; `can_accept` = !out_valid || out_ready (combinational path out_ready → in_ready). Simultaneous output transfer and accept replaces the word in the same edge; full throughput.
- `out_data`/`out_src` are stable while `out_valid && !out_ready`.

## Timing
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_src=0, skid entry empty; in_ready forced to all-zero while rst_n is low.
- First cycle after release: in_ready[sel]=1 if sel < N.
- Latency: accepted word appears on out_data/out_valid the cycle after the accept edge.
- Throughput: one word per cycle while out_ready held high, both modes.
- Reset mid-transfer: all held words discarded, no partial output.
- out_valid never drops without a transfer.

## Configuration
- `MUX_N_PIPE_SKID_EN` defined: output stage is a 2-entry skid buffer (main + skid register). `can_accept` = skid entry empty — registered, no combinational out_ready → in_ready path. A word accepted while main is stalled goes to skid; on the next transfer skid moves to main. Order preserved. in_ready drops the cycle after the skid fills, returns the cycle after it drains.
- Undefined: single-register base mode as above; identical latency and ordering.

## Structure
- Shared package `mux_pkg`: default WIDTH (5), default N, select-width function, reset constants for data/source.
- One sub-module `mux_n_skid`: the output stage (register, or register + skid under the macro), parametrised on WIDTH+SEL_W payload; top level holds only select decode, ready fan-out and channel extraction.

## Test plan
- Reset: hold rst_n low with in_valid all 1 → out_valid=0, out_data=0, out_src=0, in_ready=0; release with sel=1 → in_ready=2'b10 next cycle.
- Basic select: WIDTH=5, N=4, in_data ch2=5'h15, sel=2, out_ready=1 → out_data=5'h15, out_src=2 one cycle later; only in_ready[2] high.
- Backpressure: out_ready=0 for 3 cycles after accepting ch1=5'h0A while sel moves to 0 and ch0=5'h11 valid → out_data holds 5'h0A; base mode in_ready=0; skid mode accepts 5'h11 once then in_ready=0; on release, outputs 5'h0A then 5'h11 in order, no loss or duplicate.
- Streaming: out_ready=1, sel fixed, 8 back-to-back words 0..7 → 8 outputs in 8 consecutive cycles, 1-cycle latency.
- Out-of-range select: N=3, sel=3, in_valid=3'b111 → in_ready=0, out_valid stays 0.
- Reset mid-operation: assert rst_n low asynchronously while output (and skid) full → out_valid drops immediately without clock; after release nothing stale is emitted.

Source files
------------

// File: rtl/mux_pkg.sv
// mux_pkg: shared defaults and helpers for the N-way registered selector.
// Optional MUX_N_PIPE_SKID_EN selects a 2-entry skid output stage.
package mux_pkg;

  localparam int WIDTH_DEF = 5;
  localparam int N_DEF     = 2;
  localparam int RST_DATA  = 0;
  localparam int RST_SRC   = 0;

  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_n_skid.sv
// mux_n_skid: output stage, one register or main+skid pair.
// MUX_N_PIPE_SKID_EN defined: skid pair with registered ready.
module mux_n_skid
  import mux_pkg::*;
#(
  parameter int             PW      = 6,
  parameter logic [PW-1:0]  RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [PW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [PW-1:0] out_data,
  input  logic          out_ready
);

  logic          mvalid;
  logic [PW-1:0] mdata;

  assign out_valid = mvalid;
  assign out_data  = mdata;

`ifdef MUX_N_PIPE_SKID_EN
  logic          svalid;
  logic [PW-1:0] sdata;
  logic          acc;
  logic          xfer;

  assign in_ready = !svalid;
  assign acc      = in_valid && in_ready;
  assign xfer     = mvalid && out_ready;

  // main refills from skid first; skid only catches words while main stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mvalid <= 1'b0;
      mdata  <= RST_VAL;
      svalid <= 1'b0;
      sdata  <= RST_VAL;
    end else if (!mvalid || xfer) begin
      if (svalid) begin
        mdata  <= sdata;
        mvalid <= 1'b1;
        svalid <= 1'b0;
      end else if (acc) begin
        mdata  <= in_data;
        mvalid <= 1'b1;
      end else begin
        mvalid <= 1'b0;
      end
    end else if (acc) begin
      sdata  <= in_data;
      svalid <= 1'b1;
    end
  end
`else
  assign in_ready = !mvalid || out_ready;

  // single register: accept replaces, otherwise drain on transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mvalid <= 1'b0;
      mdata  <= RST_VAL;
    end else if (in_valid && in_ready) begin
      mvalid <= 1'b1;
      mdata  <= in_data;
    end else if (out_ready) begin
      mvalid <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/mux_n_pipe.sv
// mux_n_pipe: N-way WIDTH-bit selector with handshaked registered output.
// MUX_N_PIPE_SKID_EN defined: output stage becomes a 2-entry skid buffer.
module mux_n_pipe
  import mux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int N     = N_DEF,
  parameter int SEL_W = sel_width(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SEL_W-1:0]   sel,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_src,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int PW = WIDTH + SEL_W;
  localparam logic [PW-1:0] RST_VAL =
    {WIDTH'(RST_DATA), SEL_W'(RST_SRC)};

  logic [WIDTH-1:0] sel_data;
  logic             sel_vld;
  logic             can_acc;
  logic [PW-1:0]    opay;

  // extract the selected channel; out-of-range sel matches nothing
  always_comb begin
    sel_data = '0;
    sel_vld  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel == SEL_W'(i)) begin
        sel_data = in_data[i*WIDTH +: WIDTH];
        sel_vld  = in_valid[i];
      end
    end
  end

  // ready goes only to the selected channel, never during reset
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = rst_n && can_acc && (sel == SEL_W'(i));
    end
  end

  mux_n_skid #(
    .PW      (PW),
    .RST_VAL (RST_VAL)
  ) u_stage (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (sel_vld && rst_n),
    .in_data   ({sel_data, sel}),
    .in_ready  (can_acc),
    .out_valid (out_valid),
    .out_data  (opay),
    .out_ready (out_ready)
  );

  assign out_data = opay[PW-1:SEL_W];
  assign out_src  = opay[SEL_W-1:0];

endmodule

// File: tb/tb_mux_n_pipe.sv
// tb_mux_n_pipe: directed checks on N=4, N=2 and N=3 instances.
// Expectations adapt to MUX_N_PIPE_SKID_EN where behaviour differs.
module tb_mux_n_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [19:0] d4;
  logic [3:0]  v4, r4;
  logic [1:0]  sel4, os4;
  logic [4:0]  od4;
  logic        ov4, ordy4;

  logic [9:0]  d2;
  logic [1:0]  v2, r2;
  logic        sel2, os2;
  logic [4:0]  od2;
  logic        ov2, ordy2;

  logic [14:0] d3;
  logic [2:0]  v3, r3;
  logic [1:0]  sel3, os3;
  logic [4:0]  od3;
  logic        ov3, ordy3;

  mux_n_pipe #(.WIDTH(5), .N(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_data(d4), .in_valid(v4),
    .in_ready(r4), .sel(sel4), .out_data(od4), .out_src(os4),
    .out_valid(ov4), .out_ready(ordy4));

  mux_n_pipe #(.WIDTH(5), .N(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_data(d2), .in_valid(v2),
    .in_ready(r2), .sel(sel2), .out_data(od2), .out_src(os2),
    .out_valid(ov2), .out_ready(ordy2));

  mux_n_pipe #(.WIDTH(5), .N(3)) u3 (
    .clk(clk), .rst_n(rst_n), .in_data(d3), .in_valid(v3),
    .in_ready(r3), .sel(sel3), .out_data(od3), .out_src(os3),
    .out_valid(ov3), .out_ready(ordy3));

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    d4 = '0; v4 = 4'b1111; sel4 = 2'd1; ordy4 = 1'b1;
    d2 = {5'h03, 5'h04}; v2 = 2'b11; sel2 = 1'b1; ordy2 = 1'b1;
    d3 = {5'h07, 5'h06, 5'h05}; v3 = 3'b111; sel3 = 2'd3; ordy3 = 1'b1;

    // reset held
    tick(); tick();
    chk("rst_ov", 32'(ov4), 32'd0);
    chk("rst_od", 32'(od4), 32'd0);
    chk("rst_os", 32'(os4), 32'd0);
    chk("rst_rdy4", 32'(r4), 32'd0);
    chk("rst_rdy2", 32'(r2), 32'd0);
    v4 = '0;
    #2 rst_n = 1'b1;
    tick();
    chk("rel_rdy2", 32'(r2), 32'b10);
    chk("rel_ov2", 32'(ov2), 32'd1);
    chk("rel_od2", 32'(od2), 32'h03);

    // basic select
    d4 = {5'h1E, 5'h15, 5'h0C, 5'h02};
    sel4 = 2'd2; v4 = 4'b0100; ordy4 = 1'b1;
    #1 chk("bas_rdy", 32'(r4), 32'b0100);
    tick();
    chk("bas_ov", 32'(ov4), 32'd1);
    chk("bas_od", 32'(od4), 32'h15);
    chk("bas_os", 32'(os4), 32'd2);
    v4 = '0;
    tick();
    chk("bas_drain", 32'(ov4), 32'd0);

    // backpressure
    d4 = {5'h00, 5'h00, 5'h0A, 5'h11};
    sel4 = 2'd1; v4 = 4'b0010; ordy4 = 1'b0;
    tick();
    sel4 = 2'd0; v4 = 4'b0001;
    #1;
`ifdef MUX_N_PIPE_SKID_EN
    chk("bp_rdy0", 32'(r4), 32'b0001);
`else
    chk("bp_rdy0", 32'(r4), 32'b0000);
`endif
    for (int k = 0; k < 3; k++) begin
      chk("bp_ov", 32'(ov4), 32'd1);
      chk("bp_od", 32'(od4), 32'h0A);
      chk("bp_os", 32'(os4), 32'd1);
      tick();
      chk("bp_rdy", 32'(r4), 32'd0);
    end
    ordy4 = 1'b1;
`ifdef MUX_N_PIPE_SKID_EN
    v4 = '0;
`else
    #1 chk("bp_rel_rdy", 32'(r4), 32'b0001);
`endif
    tick();
    v4 = '0;
    chk("bp_2nd_ov", 32'(ov4), 32'd1);
    chk("bp_2nd_od", 32'(od4), 32'h11);
    chk("bp_2nd_os", 32'(os4), 32'd0);
    tick();
    chk("bp_nodup", 32'(ov4), 32'd0);

    // streaming
    sel4 = 2'd3; ordy4 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      d4 = {5'(k), 15'h0};
      v4 = 4'b1000;
      tick();
      chk("str_ov", 32'(ov4), 32'd1);
      chk("str_od", 32'(od4), 32'(k));
    end
    v4 = '0;
    tick();
    chk("str_end", 32'(ov4), 32'd0);

    // out-of-range select on N=3
    chk("oor_rdy", 32'(r3), 32'd0);
    chk("oor_ov", 32'(ov3), 32'd0);

    // reset mid-operation
    d4 = {5'h00, 5'h00, 5'h1F, 5'h00};
    sel4 = 2'd1; v4 = 4'b0010; ordy4 = 1'b0;
    tick();
    tick();
    v4 = '0;
    chk("mid_full", 32'(ov4), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_ov", 32'(ov4), 32'd0);
    chk("mid_od", 32'(od4), 32'd0);
    chk("mid_rdy", 32'(r4), 32'd0);
    tick();
    rst_n = 1'b1;
    ordy4 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mid_stale", 32'(ov4), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
